pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer running on the free-running reference clock.
// Holds the PLL in reset, waits for a synchronized lock, requires a stable
// lock window before releasing the downstream reset, retries on timeout and
// latches a fault after too many consecutive lock timeouts.
// Ports:
//   clk             free-running reference clock (never a PLL output)
//   reset           asynchronous active-low reset
//   pll_lock        PLL LOCK, asynchronous to clk
//   force_relock    single-cycle request to re-run the lock sequence
//   pll_resetb      PLL RESETB (low holds the PLL in reset)
//   sys_reset_n     active-low reset for PLL-clocked logic
//   ready           high only while running
//   fault           high only in the fault state
//   lock_loss_count saturating count of lock losses seen while running
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1200,
  parameter int unsigned STABLE_CYCLES = 120,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       force_relock,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned MAX_RL  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_RL > STABLE_CYCLES) ? MAX_RL : STABLE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);

  // Counter compares against "last cycle" values, so it never exceeds limit-1.
  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  state_t        state;
  logic          lock_m;
  logic          lock_s;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= RESET_PLL;
      cnt             <= '0;
      retry           <= '0;
      pll_resetb      <= 1'b0;
      sys_reset_n     <= 1'b0;
      ready           <= 1'b0;
      fault           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (force_relock) begin
            cnt <= '0;
          end else if (cnt == RESET_LAST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_resetb <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_LOCK: begin
          if (force_relock) begin
            state      <= RESET_PLL;
            cnt        <= '0;
            pll_resetb <= 1'b0;
          end else if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt        <= '0;
            pll_resetb <= 1'b0;
            retry      <= retry + RW'(1);
            if (retry == RETRY_LAST) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= RESET_PLL;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STABLE: begin
          if (force_relock) begin
            state      <= RESET_PLL;
            cnt        <= '0;
            pll_resetb <= 1'b0;
          end else if (!lock_s) begin
            // Glitch: restart the lock timeout, keep the retry count.
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            retry       <= '0;
            sys_reset_n <= 1'b1;
            ready       <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RUN: begin
          // A lock loss counts once even when a relock request coincides.
          if (!lock_s || force_relock) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            pll_resetb  <= 1'b0;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            if (!lock_s && (lock_loss_count != 8'hFF)) begin
              lock_loss_count <= lock_loss_count + 8'd1;
            end
          end
        end

        FAULT: begin
          // Terminal until reset; relock requests are ignored.
          pll_resetb <= 1'b0;
          fault      <= 1'b1;
        end

        default: begin
          state       <= RESET_PLL;
          cnt         <= '0;
          pll_resetb  <= 1'b0;
          sys_reset_n <= 1'b0;
          ready       <= 1'b0;
          fault       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/relock
// stimulus, checked cycle by cycle against a timestamp-based reference model.
module tb_pll_reset_sequencer;

  localparam int unsigned RC = 4;
  localparam int unsigned LT = 20;
  localparam int unsigned SC = 8;
  localparam int unsigned MR = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       force_relock;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_count;

  pll_reset_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_lock       (pll_lock),
    .force_relock   (force_relock),
    .pll_resetb     (pll_resetb),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .fault          (fault),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  bit rst_hold;

  // Reference model: phase plus the edge index at which it was entered.
  typedef enum {M_RST, M_WAIT, M_STB, M_RUN, M_FLT} mph_t;
  mph_t ph;
  int   t;
  int   t_enter;
  int   tries;
  int   losses;
  bit   sa, sb;

  function automatic logic [11:0] m_out();
    logic [7:0] c;
    c = (losses > 255) ? 8'd255 : 8'(losses);
    return {(ph != M_RST) && (ph != M_FLT), ph == M_RUN, ph == M_RUN, ph == M_FLT, c};
  endfunction

  task automatic m_reset();
    ph = M_RST; t_enter = t; tries = 0; losses = 0; sa = 1'b0; sb = 1'b0;
  endtask

  task automatic m_enter(input mph_t p);
    ph = p; t_enter = t;
  endtask

  // Advance the model by one clock edge.
  task automatic m_step(input bit lk_in, input bit fr, input bit in_reset);
    bit lk;
    int age;
    t++;
    if (in_reset) begin
      m_reset();
      return;
    end
    lk = sb; sb = sa; sa = lk_in;
    age = t - t_enter;
    case (ph)
      M_RST:  if (fr) m_enter(M_RST);
              else if (age >= int'(RC)) m_enter(M_WAIT);
      M_WAIT: if (fr) m_enter(M_RST);
              else if (lk) m_enter(M_STB);
              else if (age >= int'(LT)) begin
                tries++;
                m_enter((tries >= int'(MR)) ? M_FLT : M_RST);
              end
      M_STB:  if (fr) m_enter(M_RST);
              else if (!lk) m_enter(M_WAIT);
              else if (age >= int'(SC)) begin tries = 0; m_enter(M_RUN); end
      M_RUN:  if (!lk) begin losses++; m_enter(M_RST); end
              else if (fr) m_enter(M_RST);
      default: ;
    endcase
  endtask

  // One clock of stimulus; pushes the expected post-edge outputs.
  task automatic cyc(input bit lk, input bit fr);
    @(negedge clk);
    pll_lock = lk;
    force_relock = fr;
    if (rst_hold) begin
      if (reset) begin
        reset = 1'b0;
        m_reset();
        exp_q.push_back(m_out());
      end
    end else begin
      reset = 1'b1;
    end
    m_step(lk, fr, rst_hold);
    exp_q.push_back(m_out());
  endtask

  task automatic do_reset();
    rst_hold = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst_hold = 1'b0;
  endtask

  // Monitor: compares outputs after every edge and right after reset assertion.
  logic [11:0] got, e;
  always @(posedge clk or negedge reset) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {pll_resetb, sys_reset_n, ready, fault, lock_loss_count};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got resetb=%b sys_reset_n=%b ready=%b fault=%b count=%0d, expected resetb=%b sys_reset_n=%b ready=%b fault=%b count=%0d",
                 $time, got[11], got[10], got[9], got[8], got[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of stimulus by %0t, expected completion", $time);
    $fatal(1);
  end

  bit v;
  int len;
  initial begin
    reset = 1'b0; pll_lock = 1'b0; force_relock = 1'b0; rst_hold = 1'b1;
    t = 0;
    m_reset();
    cyc(1'b0, 1'b0);
    rst_hold = 1'b0;

    // Nominal lock: lock rises 5 cycles after pll_resetb releases.
    repeat (RC + 5) cyc(1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0);

    // One-cycle lock glitch during the stable window.
    do_reset();
    repeat (RC + 5) cyc(1'b0, 1'b0);
    repeat (7) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (16) cyc(1'b1, 1'b0);

    // Timeouts into FAULT, relock requests ignored, reset clears it.
    do_reset();
    repeat (60) cyc(1'b0, 1'b0);
    repeat (10) cyc(1'($urandom_range(0, 1)), 1'b1);
    do_reset();
    repeat (6) cyc(1'b0, 1'b0);

    // Async reset in the middle of the lock wait.
    do_reset();

    // Reach RUN, then lock losses, plain relock, and coincident loss+relock.
    repeat (20) cyc(1'b1, 1'b0);
    repeat (3) begin
      cyc(1'b0, 1'b0);
      repeat (17) cyc(1'b1, 1'b0);
    end
    cyc(1'b1, 1'b1);
    repeat (17) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (18) cyc(1'b1, 1'b0);

    // Enough losses to saturate the counter.
    repeat (256) begin
      cyc(1'b0, 1'b0);
      repeat (17) cyc(1'b1, 1'b0);
    end

    // Random lock segments with occasional relock requests and resets.
    for (int seg = 0; seg < 150; seg++) begin
      v = ($urandom_range(0, 3) != 0);
      len = int'($urandom_range(1, 30));
      if ($urandom_range(0, 29) == 0) do_reset();
      for (int i = 0; i < len; i++) cyc(v, $urandom_range(0, 39) == 0);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
